cmd_frame_parser: RTL

//  Downstream of the UART receive stage. Consumes received bytes (rx_data + 1-cycle rx_valid).

---
 rtl/cmd_frame_parser_pkg.sv | 36 +++
 rtl/cmd_frame_parser_byte_timeout.sv | 47 ++++
 rtl/cmd_frame_parser.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// cmd_frame_parser_pkg: shared types and constants for the command frame parser.
//   parser_state_e - frame assembly FSM states
//   frame_t        - latched ADDR/D_HI/D_LO bytes of the frame in progress
//   frame_chk()    - expected checksum of a latched frame
//   addr_known()   - true for the two writable set-point addresses
package cmd_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4
  } parser_state_e;

  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
  localparam logic [7:0]  ADDR_S1          = 8'h01;
  localparam logic [7:0]  ADDR_S2          = 8'h02;
  localparam logic [15:0] STOR_MAX_VAL_DEF = 16'd4000;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] d_hi;
    logic [7:0] d_lo;
  } frame_t;

  // Checksum a sender must place in the CHK byte
  function automatic logic [7:0] frame_chk(input frame_t f);
    return f.addr ^ f.d_hi ^ f.d_lo;
  endfunction

  function automatic logic addr_known(input logic [7:0] a);
    return (a == ADDR_S1) || (a == ADDR_S2);
  endfunction

endpackage

// File: rtl/cmd_frame_parser_byte_timeout.sv
// byte_timeout: inter-byte gap watchdog for the frame parser.
//   clk, rst_n - clock, asynchronous active-low reset (counter resets to TMO)
//   reload     - reload counter to TMO (a byte arrived)
//   run        - count down while a frame is in progress
//   expired    - registered flag, high while the counter sits at zero during a run
//                with no reload pending; the consumer gives a same-cycle byte priority
module byte_timeout #(
  parameter int unsigned CLK_MHZ    = 100,
  parameter int unsigned TIMEOUT_US = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic run,
  output logic expired
);

  localparam int unsigned TMO   = CLK_MHZ * TIMEOUT_US - 1;
  localparam int unsigned CNT_W = (TMO > 0) ? $clog2(TMO + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Reload wins over countdown; counter saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = CNT_W'(TMO);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    expired_d = run && !reload && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= CNT_W'(TMO);
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: assembles 5-byte command frames (A5, ADDR, D_HI, D_LO, CHK)
// from the UART receive stage and writes the set-point registers.
//   clk, rst_n           - clock, asynchronous active-low reset
//   rx_data, rx_valid    - received byte and its 1-cycle strobe
//   storage_1, storage_2 - set-points (pulse width, period)
//   upd                  - 1-cycle pulse after a good frame wrote a set-point
//   frame_err            - 1-cycle pulse after a rejected frame (checksum, address, timeout)
//   busy                 - high while a frame is in progress
// Build option: define CMD_PARSER_CLAMP_EN to saturate written values at STOR_MAX_VAL.
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 100,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned STOR_W     = 16
`ifdef CMD_PARSER_CLAMP_EN
  ,
  parameter logic [STOR_W-1:0] STOR_MAX_VAL = STOR_W'(STOR_MAX_VAL_DEF)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [STOR_W-1:0] storage_1,
  output logic [STOR_W-1:0] storage_2,
  output logic              upd,
  output logic              frame_err,
  output logic              busy
);

  parser_state_e     state_q, state_d;
  frame_t            frame_q, frame_d;
  logic [STOR_W-1:0] stor1_q, stor1_d;
  logic [STOR_W-1:0] stor2_q, stor2_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              run_c;
  logic              tmo_expired;
  logic              frame_ok_c;
  logic [STOR_W-1:0] val_raw_c;
  logic [STOR_W-1:0] val_wr_c;

  assign run_c = (state_q != ST_IDLE);

  // Every received byte restarts the gap timer, including the sync byte
  byte_timeout #(
    .CLK_MHZ   (CLK_MHZ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_byte_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (rx_valid),
    .run    (run_c),
    .expired(tmo_expired)
  );

  // Value from the latched data bytes; narrower set-points keep the LSBs
  assign val_raw_c  = STOR_W'({frame_q.d_hi, frame_q.d_lo});
  assign frame_ok_c = (rx_data == frame_chk(frame_q)) && addr_known(frame_q.addr);

`ifdef CMD_PARSER_CLAMP_EN
  assign val_wr_c = (val_raw_c > STOR_MAX_VAL) ? STOR_MAX_VAL : val_raw_c;
`else
  assign val_wr_c = val_raw_c;
`endif

  // Frame FSM: advances only on received bytes; a byte beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    stor1_d = stor1_q;
    stor2_d = stor2_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          frame_d.addr = rx_data;
          state_d      = ST_DHI;
        end
        ST_DHI: begin
          frame_d.d_hi = rx_data;
          state_d      = ST_DLO;
        end
        ST_DLO: begin
          frame_d.d_lo = rx_data;
          state_d      = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (frame_ok_c) begin
            if (frame_q.addr == ADDR_S1) begin
              stor1_d = val_wr_c;
            end else begin
              stor2_d = val_wr_c;
            end
            upd_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (run_c && tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      stor1_q <= '0;
      stor2_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      stor1_q <= stor1_d;
      stor2_q <= stor2_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign storage_1 = stor1_q;
  assign storage_2 = stor2_q;
  assign upd       = upd_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule
